// File: rtl/mips_run_ctrl_if.sv
// Run-control bus between the sequencer and the core/board environment.
// The master modport is the sequencer side: it samples the core status
// inputs and drives reset, clock enable and run status.
interface mips_run_ctrl_if #(
    parameter int NCH   = 2,
    parameter int CNT_W = 32
);
    logic             step_mode;
    logic             step_req;
    logic             halt_in;
    logic             retire;
    logic [NCH-1:0]   core_rst;
    logic             core_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       state;
    logic             done;
    logic             wdog_trip;

    modport master (
        input  step_mode, step_req, halt_in, retire,
        output core_rst, core_en, cycle_cnt, state, done, wdog_trip
    );

    modport slave (
        output step_mode, step_req, halt_in, retire,
        input  core_rst, core_en, cycle_cnt, state, done, wdog_trip
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run-control and reset sequencer for the pipelined MIPS core.
// After the board reset is removed, the core reset channels are released
// one by one. The block then gates the core with a clock enable, in either
// free-run or single-step mode. It counts enabled cycles, saturating at
// the top of the counter, and stops for good when the core reports a halt.
// Optional watchdog: define MIPS_RUN_CTRL_WDOG_EN to halt the core after
// WDOG enabled cycles with no retired instruction.
module mips_run_ctrl #(
    parameter int NCH     = 2,
    parameter int HOLD    = 4,
    parameter int STAGGER = 1,
    parameter int CNT_W   = 32,
    parameter int WDOG    = 1000
) (
    input  logic               clk,
    input  logic               rst,
    mips_run_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        S_HOLD    = 2'b00,
        S_RELEASE = 2'b01,
        S_RUN     = 2'b10,
        S_HALT    = 2'b11
    } state_e;

    // Edge (counted from reset removal) at which the last channel releases.
    localparam int LAST_EDGE = HOLD + (NCH - 1) * STAGGER;
    // Wide enough to hold LAST_EDGE+1, the edge that enters RUN.
    localparam int SEQ_W     = $clog2(LAST_EDGE + 2);

    state_e             state_q, state_d;
    logic [NCH-1:0]     core_rst_q, core_rst_d;
    logic               core_en_q, core_en_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               step_prev_q, step_prev_d;
    logic               halt_take;
    logic               wd_expire;
    int                 edge_n;

    // Saturating increment: the counter sticks at all ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + CNT_W'(1);
    endfunction

    // A halt only counts in a cycle where the core was actually enabled.
    assign halt_take = core_en_q & bus.halt_in;
    // Number of the edge that is about to occur, counted from reset removal.
    assign edge_n    = int'(seq_q) + 1;

`ifdef MIPS_RUN_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wtrip_q;

    // The watchdog expires on the edge where the idle count reaches WDOG.
    assign wd_expire = core_en_q && !bus.retire && (wd_q == WD_W'(WDOG - 1));

    // Idle-cycle count: advances on enabled cycles, cleared by any retire.
    always_comb begin
        wd_d = wd_q;
        if (core_en_q)
            wd_d = bus.retire ? '0 : wd_q + WD_W'(1);
    end

    // Watchdog registers. A coincident halt_in takes priority over the trip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            wtrip_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_expire && !halt_take)
                wtrip_q <= 1'b1;
        end
    end

    assign bus.wdog_trip = wtrip_q;
`else
    logic unused_wdog;

    assign wd_expire     = 1'b0;
    assign bus.wdog_trip = 1'b0;
    // retire and WDOG only matter to the watchdog.
    assign unused_wdog   = bus.retire ^ (WDOG > 0);
`endif

    // Next-state logic: reset release sequence, run gating and halt.
    always_comb begin
        state_d     = state_q;
        core_rst_d  = core_rst_q;
        core_en_d   = 1'b0;
        cnt_d       = core_en_q ? sat_inc(cnt_q) : cnt_q;
        done_d      = done_q;
        seq_d       = seq_q;
        step_prev_d = 1'b0;

        case (state_q)
            S_HOLD: begin
                seq_d = seq_q + SEQ_W'(1);
                if (edge_n >= HOLD) begin
                    core_rst_d[0] = 1'b0;
                    state_d       = S_RELEASE;
                end
            end

            S_RELEASE: begin
                seq_d = seq_q + SEQ_W'(1);
                for (int i = 0; i < NCH; i++) begin
                    if (edge_n >= HOLD + i * STAGGER)
                        core_rst_d[i] = 1'b0;
                end
                if (edge_n > LAST_EDGE) begin
                    // This is the first RUN edge. The step detector's history
                    // is still clear here, so a step_req already high at this
                    // edge gives a step pulse.
                    state_d     = S_RUN;
                    core_en_d   = bus.step_mode ? bus.step_req : 1'b1;
                    step_prev_d = bus.step_req;
                end
            end

            S_RUN: begin
                step_prev_d = bus.step_req;
                if (halt_take) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else if (wd_expire) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else if (bus.step_mode) begin
                    core_en_d = bus.step_req & ~step_prev_q;
                end else begin
                    core_en_d = 1'b1;
                end
            end

            default: begin
                // HALT is terminal: everything holds until rst.
                cnt_d = cnt_q;
            end
        endcase
    end

    // Control registers, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HOLD;
            core_rst_q  <= '1;
            core_en_q   <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            seq_q       <= '0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            seq_q       <= seq_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.core_en   = core_en_q;
    assign bus.cycle_cnt = cnt_q;
    assign bus.done      = done_q;

endmodule
